// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared glyph constants, hex-to-segment decoder and scan-state
//               type for the multiplexed 7-segment display driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

  // Active-low {g,f,e,d,c,b,a}: all segments off, and the error glyph 'E'.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'b000_0110;

  typedef enum logic {
    SCAN_BLANK = 1'b0,
    SCAN_DRIVE = 1'b1
  } scan_state_t;

  // Hex nibble to active-low glyph (0-9, A, b, C, d, E, F).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b100_0000;
      4'h1:    s = 7'b111_1001;
      4'h2:    s = 7'b010_0100;
      4'h3:    s = 7'b011_0000;
      4'h4:    s = 7'b001_1001;
      4'h5:    s = 7'b001_0010;
      4'h6:    s = 7'b000_0010;
      4'h7:    s = 7'b111_1000;
      4'h8:    s = 7'b000_0000;
      4'h9:    s = 7'b001_0000;
      4'hA:    s = 7'b000_1000;
      4'hB:    s = 7'b000_0011;
      4'hC:    s = 7'b100_0110;
      4'hD:    s = 7'b010_0001;
      4'hE:    s = 7'b000_0110;
      default: s = 7'b000_1110;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_display_driver_scan_timer.sv
`default_nettype none
// ============================================================================
// Module      : scan_timer
// Description : BLANK/DRIVE digit-scan sequencer. One BLANK cycle between
//               digits, REFRESH_DIV-1 DRIVE cycles per digit, 4 digits.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_timer
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] idx_o,
  output logic       drive_en_o,
  output logic       digit_advance_o
);

  localparam int             CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 2);

  // A period shorter than 4 leaves no room for a DRIVE phase worth having.
  if (REFRESH_DIV < 4) begin : g_refresh_div_check
    $error("scan_timer: REFRESH_DIV must be >= 4");
  end

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             adv;

  // State, cycle counter and digit index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN_BLANK;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: BLANK lasts one cycle; DRIVE counts 0..REFRESH_DIV-2.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    adv     = 1'b0;
    case (state_q)
      SCAN_BLANK: begin
        state_d = SCAN_DRIVE;
        cnt_d   = '0;
      end
      SCAN_DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = SCAN_BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          adv     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SCAN_BLANK;
    endcase
  end

  assign idx_o           = idx_q;
  assign drive_en_o      = (state_q == SCAN_DRIVE);
  assign digit_advance_o = adv;

endmodule
`default_nettype wire

// File: rtl/seg_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_driver
// Description : 4-digit common-anode multiplexed 7-segment driver: reset
//               synchronizer, result hold, status hex digit with error blink,
//               anti-ghost blank cycle between digits, registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_driver
  import seg_pkg::*;
#(
  parameter int         REFRESH_DIV = 100_000,
  parameter int         BLINK_DIV   = 25_000_000,
  parameter logic [3:0] ERR_CODE    = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n_pin,
  input  logic       result_valid,
  input  logic [3:0] result_digit,
  input  logic [3:0] status_code,
  input  logic       clear,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int             BLK_W    = $clog2(BLINK_DIV);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [1:0]       rst_sync_q;
  logic             rst_n;
  logic             have_q, have_d;
  logic [3:0]       val_q, val_d;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             blink_q, blink_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       an_q, an_d;
  logic [1:0]       idx;
  logic             drive_en;
  logic             digit_advance;

  // Reset synchronizer: asserts with the pin, releases two clk edges later.
  always_ff @(posedge clk or negedge rst_n_pin) begin
    if (!rst_n_pin) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  scan_timer #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_scan_timer (
    .clk             (clk),
    .rst_n           (rst_n),
    .idx_o           (idx),
    .drive_en_o      (drive_en),
    .digit_advance_o (digit_advance)
  );

  // A digit may only advance out of the DRIVE phase.
  a_adv_in_drive: assert property (@(posedge clk) disable iff (!rst_n)
                                   digit_advance |-> drive_en);

  // Result hold (valid beats clear) and free-running blink divider.
  always_comb begin
    have_d    = have_q;
    val_d     = val_q;
    blk_cnt_d = blk_cnt_q + 1'b1;
    blink_d   = blink_q;
    if (result_valid) begin
      have_d = 1'b1;
      val_d  = result_digit;
    end else if (clear) begin
      have_d = 1'b0;
    end
    if (blk_cnt_q == BLK_LAST) begin
      blk_cnt_d = '0;
      blink_d   = ~blink_q;
    end
  end

  // Content mux: anodes and glyph for the digit currently being driven.
  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    an_d  = 4'hF;
    if (drive_en) begin
      an_d = ~(4'b0001 << idx);
      case (idx)
        2'd0: begin
          if (have_q) seg_d = (val_q <= 4'd9) ? hex_to_seg(val_q) : SEG_E;
        end
        2'd1: dp_d = ~have_q;
        2'd2: begin
          if (!((status_code == ERR_CODE) && blink_q)) seg_d = hex_to_seg(status_code);
        end
        default: seg_d = SEG_BLANK;
      endcase
    end
  end

  // Result, blink and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_q    <= 1'b0;
      val_q     <= 4'd0;
      blk_cnt_q <= '0;
      blink_q   <= 1'b0;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
      an_q      <= 4'hF;
    end else begin
      have_q    <= have_d;
      val_q     <= val_d;
      blk_cnt_q <= blk_cnt_d;
      blink_q   <= blink_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_driver
// Description : Directed self-checking bench for seg_display_driver
//               (REFRESH_DIV=8, BLINK_DIV=64).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_driver;

  logic       clk = 1'b0;
  logic       rst_n_pin;
  logic       result_valid;
  logic [3:0] result_digit;
  logic [3:0] status_code;
  logic       clear;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int errors = 0;
  int checks = 0;
  logic [31:0] ecnt;   // rising edges since rst_n_pin released

  seg_display_driver #(
    .REFRESH_DIV(8),
    .BLINK_DIV  (64),
    .ERR_CODE   (4'hF)
  ) dut (
    .clk          (clk),
    .rst_n_pin    (rst_n_pin),
    .result_valid (result_valid),
    .result_digit (result_digit),
    .status_code  (status_code),
    .clear        (clear),
    .seg          (seg),
    .dp           (dp),
    .an           (an)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n_pin) ecnt <= 32'd0;
    else            ecnt <= ecnt + 32'd1;
  end

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_an(input logic [3:0] a, input int budget, input string tag);
    int n;
    n = 0;
    while (an !== a && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {6'd0, an === a}, 7'd1);
  endtask

  // Skip to a fresh appearance of digit a (past an intervening blank cycle).
  task automatic wait_digit(input logic [3:0] a, input string tag);
    wait_an(4'hF, 40, {tag, "_blank"});
    wait_an(a, 40, tag);
  endtask

  task automatic pulse(input logic v, input logic c, input logic [3:0] d);
    @(negedge clk);
    result_valid = v;
    clear        = c;
    result_digit = d;
    @(negedge clk);
    result_valid = 1'b0;
    clear        = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int n;
    bit found;

    rst_n_pin    = 1'b0;
    result_valid = 1'b0;
    result_digit = 4'd0;
    status_code  = 4'd0;
    clear        = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_an", {3'd0, an}, 7'h0F);
    chk("rst_dp", {6'd0, dp}, 7'd1);

    // Release: two sync edges, one BLANK output cycle, then digit 0.
    rst_n_pin = 1'b1;
    @(negedge clk); chk("rel_e1_an", {3'd0, an}, 7'h0F);
    @(negedge clk); chk("rel_e2_an", {3'd0, an}, 7'h0F);
    @(negedge clk); chk("rel_e3_an", {3'd0, an}, 7'h0F);
    @(negedge clk); chk("rel_e4_an", {3'd0, an}, 7'h0E);
    chk("rel_seg_nores", seg, 7'h7F);

    // Scan order: 7 drive cycles per digit, one blank cycle between.
    for (int i = 0; i < 32; i++) begin
      exp_an = ((i % 8) < 7) ? ~(4'b0001 << (i / 8)) : 4'hF;
      chk("scan_an", {3'd0, an}, {3'd0, exp_an});
      if (i == 8)  chk("scan_d1_dp", {6'd0, dp}, 7'd1);
      if (i == 16) chk("scan_d2_stat0", seg, 7'b100_0000);
      if (i == 24) chk("scan_d3_seg", seg, 7'h7F);
      @(negedge clk);
    end

    // Result latch of 7, visible on digit 0 within the worst-case latency.
    pulse(1'b1, 1'b0, 4'd7);
    found = 1'b0;
    n = 0;
    while (!found && n < 34) begin
      if (an === 4'hE && seg === 7'b111_1000) found = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("res7_latency", {6'd0, found}, 7'd1);
    wait_digit(4'hE, "w_res7");
    chk("res7_seg", seg, 7'b111_1000);
    wait_digit(4'hD, "w_res7_d1");
    chk("res7_dp", {6'd0, dp}, 7'd0);
    chk("res7_d1_seg", seg, 7'h7F);

    // Status hex digit.
    status_code = 4'hA;
    wait_digit(4'hB, "w_statA");
    chk("statA_seg", seg, 7'b000_1000);
    chk("statA_dp", {6'd0, dp}, 7'd1);

    // Error blink: phase derived from edges since release.
    status_code = 4'hF;
    wait_digit(4'hB, "w_statF");
    for (int i = 0; i < 260; i++) begin
      if (an === 4'hB) begin
        exp_seg = (((ecnt - 32'd3) / 32'd64) % 32'd2 == 32'd1) ? 7'h7F : 7'b000_1110;
        chk("blink_seg", seg, exp_seg);
      end
      @(negedge clk);
    end

    status_code = 4'hA;
    wait_digit(4'hB, "w_statA2");
    chk("statA2_seg", seg, 7'b000_1000);

    // Clear alone, then clear+valid collision (valid wins).
    pulse(1'b0, 1'b1, 4'd0);
    wait_digit(4'hE, "w_clr");
    chk("clr_seg", seg, 7'h7F);
    wait_digit(4'hD, "w_clr_d1");
    chk("clr_dp", {6'd0, dp}, 7'd1);

    pulse(1'b1, 1'b1, 4'd3);
    wait_digit(4'hE, "w_coll");
    chk("coll_seg", seg, 7'b011_0000);
    wait_digit(4'hD, "w_coll_d1");
    chk("coll_dp", {6'd0, dp}, 7'd0);

    // Illegal digit shows E.
    pulse(1'b1, 1'b0, 4'd12);
    wait_digit(4'hE, "w_ill");
    chk("ill_seg", seg, 7'b000_0110);

    // Asynchronous reset mid-DRIVE, then restart from digit 0.
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_an", {3'd0, an}, 7'h0E);
    rst_n_pin = 1'b0;
    #1;
    chk("arst_seg", seg, 7'h7F);
    chk("arst_an", {3'd0, an}, 7'h0F);
    chk("arst_dp", {6'd0, dp}, 7'd1);
    repeat (3) @(negedge clk);
    rst_n_pin = 1'b1;
    wait_an(4'hE, 12, "w_rerel");
    chk("rerel_seg", seg, 7'h7F);
    chk("rerel_lat", {3'd0, ecnt[3:0]}, 7'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
